sap_controller: RTL and testbench
=================================

Name: sap_controller

Overview:
Controller-sequencer for the 4-bit bus computer. It steps a six-state T-cycle ring (fetch T1–T3, execute T4–T6) and decodes the instruction-register opcode. Each cycle it drives one control word to the program counter, MAR, RAM, IR, A/B registers, ALU and output register. It also owns program-counter clear and the halt condition.

Parameters:
EARLY_RETIRE, 0, when 1 an instruction with no remaining active T-states returns to T1 right after its last active state instead of idling through T6.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  4  IR upper nibble; valid from T4 onward
pc_clr_n  out  1  program-counter clear, active-low
pc_cp  out  1  PC count enable
pc_ep  out  1  PC bus enable (PC registers it, so it takes effect one cycle later)
pc_lp  out  1  PC load from bus
mar_lm  out  1  MAR load from bus
ram_ce  out  1  RAM drives bus
ir_li  out  1  IR load from bus
ir_ei  out  1  IR operand nibble drives bus
a_la  out  1  A load
a_ea  out  1  A drives bus
b_lb  out  1  B load
alu_su  out  1  ALU subtract select
alu_eu  out  1  ALU drives bus
out_lo  out  1  output-register load
hlt  out  1  halted flag
tstate  out  6  one-hot T1..T6; all-zero in INIT and HALT

Behaviour:
- States: INIT, T1, T2, T3, T4, T5, T6, HALT. Single registered state; every output is decoded combinationally from state and the latched opcode.
- While rst is high: state=INIT, op_q=0, pc_clr_n=0, all other outputs 0. Reset takes effect asynchronously, including mid-instruction.
- INIT lasts exactly one cycle after rst falls.
  - pc_clr_n=0 and pc_ep=1 in INIT, so the PC clears and drives the bus in T1.
  - INIT→T1.
- Fetch:
  - T1: mar_lm=1. The PC drives the bus here because pc_ep was asserted in the prior cycle.
  - T2: pc_cp=1.
  - T3: ram_ce=1, ir_li=1.
- op_q latches opcode on the T4 clock edge's preceding cycle: it is sampled in T4, and T4 decodes from the live opcode. T5 and T6 decode from op_q.
- Execute (opcodes are package constants):
  - LDA 0000: T4 ir_ei, mar_lm; T5 ram_ce, a_la.
  - ADD 0001: T4 ir_ei, mar_lm; T5 ram_ce, b_lb; T6 alu_eu, a_la, alu_su=0.
  - SUB 0010: same as ADD, except alu_su=1 during T5 and T6 (held stable across the B load).
  - JMP 0011: T4 ir_ei, pc_lp.
  - OUT 1110: T4 a_ea, out_lo.
  - HLT 1111: T4 no strobes; T4→HALT.
  - Any other opcode: NOP, no strobes.
- Last active state:
  - ADD/SUB: T6.
  - LDA: T5.
  - JMP, OUT, NOP: T4.
- Retire:
  - EARLY_RETIRE=0: every non-HLT instruction runs T4→T5→T6→T1.
  - EARLY_RETIRE=1: the last active state goes directly →T1; a NOP retires from T4.
- pc_ep=1 in whichever state transitions to T1 (INIT, T6, or the early-retire state), and only there. This includes the JMP retire state, so the loaded PC value is fetched.
- HALT:
  - hlt=1, all strobes 0, pc_clr_n=1.
  - HALT is absorbing; only rst exits it.
- Invariants, assertable in the bench:
  - At most one bus driver among {pc_ep-effective, ram_ce, ir_ei, a_ea, alu_eu} per cycle.
  - pc_cp and pc_lp are never both 1.
  - tstate is one-hot or zero.

Decomposition:
- Package sap_pkg:
  - opcode constants LDA/ADD/SUB/JMP/OUT/HLT;
  - state enum;
  - packed control-word struct;
  - T-state index constants.
- Sub-module sap_ctrl_decode: combinational (state, opcode, op_q) → control word. The parent keeps only the state register, op_q and next-state logic.

Test Plan:
- Reset release: rst high 3 cycles then low → INIT has pc_clr_n=0 and pc_ep=1; next cycle T1 (tstate=000001) with mar_lm=1; T2 pc_cp=1; T3 ram_ce=ir_li=1.
- ADD 0001 with EARLY_RETIRE=0 → T4 ir_ei+mar_lm, T5 ram_ce+b_lb, T6 alu_eu+a_la with alu_su=0 and pc_ep=1, then T1; 6 cycles per instruction.
- SUB 0010 then LDA 0000 with EARLY_RETIRE=1 → SUB takes 6 cycles with alu_su=1 in T5–T6; LDA retires from T5 with pc_ep=1 there; next T1 follows immediately (5 cycles total).
- JMP 0011 (EARLY_RETIRE=1) → T4 ir_ei=pc_lp=pc_ep=1, pc_cp=0, next state T1. OUT 1110 → T4 a_ea=out_lo=1.
- HLT 1111 → T4 no strobes; from the next cycle hlt=1 and tstate=0 for 20+ cycles while opcode is toggled; rst pulse returns to INIT.
- rst asserted asynchronously mid-T5 of an ADD → outputs zero and pc_clr_n=0 within the same cycle without waiting for a clock edge; clean fetch after release. An unknown opcode 0101 behaves as NOP and the bus-driver invariant holds throughout.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the 4-bit bus computer controller-sequencer:
// opcodes, T-state encoding, the control word layout and the retire rule.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Bit positions of each T-state in the one-hot tstate vector.
    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    // One cycle's worth of control strobes plus status.
    typedef struct packed {
        logic       pc_clr_n;
        logic       pc_cp;
        logic       pc_ep;
        logic       pc_lp;
        logic       mar_lm;
        logic       ram_ce;
        logic       ir_li;
        logic       ir_ei;
        logic       a_la;
        logic       a_ea;
        logic       b_lb;
        logic       alu_su;
        logic       alu_eu;
        logic       out_lo;
        logic       hlt;
        logic [5:0] tstate;
    } ctrl_word_t;

    // Last execute state that carries strobes for an opcode. HLT never
    // retires to T1, so it reports HALT and never matches a T-state.
    function automatic state_t last_state(input logic [3:0] op);
        state_t s;
        case (op)
            OP_ADD, OP_SUB: s = S_T6;
            OP_LDA:         s = S_T5;
            OP_HLT:         s = S_HALT;
            default:        s = S_T4;
        endcase
        return s;
    endfunction

    // True when the given state hands over to T1 on the next edge.
    function automatic logic retires_at(input state_t s, input logic [3:0] op,
                                        input logic early);
        return (s == S_T6) ||
               (early && (s == S_T4 || s == S_T5) && (s == last_state(op)));
    endfunction

endpackage

// File: rtl/sap_controller_if.sv
// Control bus between the sequencer and the datapath blocks.
// Handshake: none; every strobe is a level valid for the whole cycle in
// which it is driven and acted upon by the datapath at the next rising edge.
interface sap_controller_if;
    logic [3:0] opcode;
    logic       pc_clr_n;
    logic       pc_cp;
    logic       pc_ep;
    logic       pc_lp;
    logic       mar_lm;
    logic       ram_ce;
    logic       ir_li;
    logic       ir_ei;
    logic       a_la;
    logic       a_ea;
    logic       b_lb;
    logic       alu_su;
    logic       alu_eu;
    logic       out_lo;
    logic       hlt;
    logic [5:0] tstate;

    modport master (
        input  opcode,
        output pc_clr_n, pc_cp, pc_ep, pc_lp, mar_lm, ram_ce, ir_li, ir_ei,
               a_la, a_ea, b_lb, alu_su, alu_eu, out_lo, hlt, tstate
    );

    modport slave (
        output opcode,
        input  pc_clr_n, pc_cp, pc_ep, pc_lp, mar_lm, ram_ce, ir_li, ir_ei,
               a_la, a_ea, b_lb, alu_su, alu_eu, out_lo, hlt, tstate
    );
endinterface

// File: rtl/sap_ctrl_decode.sv
// Combinational control-word decoder: T-state plus opcode to strobes.
// T4 decodes the live IR opcode; T5/T6 use the copy latched during T4.
module sap_ctrl_decode
    import sap_pkg::*;
#(
    parameter bit EARLY_RETIRE = 1'b0
) (
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [3:0] op_q,
    output ctrl_word_t cw
);

    logic [3:0] cur_op;

    assign cur_op = (state == S_T4) ? opcode : op_q;

    // Strobe decode; pc_ep is added wherever the next state is T1.
    always_comb begin
        cw          = '0;
        cw.pc_clr_n = 1'b1;
        case (state)
            S_INIT: begin
                cw.pc_clr_n = 1'b0;
                cw.pc_ep    = 1'b1;
            end
            S_T1: begin
                cw.tstate[T1_IDX] = 1'b1;
                cw.mar_lm         = 1'b1;
            end
            S_T2: begin
                cw.tstate[T2_IDX] = 1'b1;
                cw.pc_cp          = 1'b1;
            end
            S_T3: begin
                cw.tstate[T3_IDX] = 1'b1;
                cw.ram_ce         = 1'b1;
                cw.ir_li          = 1'b1;
            end
            S_T4: begin
                cw.tstate[T4_IDX] = 1'b1;
                case (cur_op)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw.ir_ei  = 1'b1;
                        cw.mar_lm = 1'b1;
                    end
                    OP_JMP: begin
                        cw.ir_ei = 1'b1;
                        cw.pc_lp = 1'b1;
                    end
                    OP_OUT: begin
                        cw.a_ea   = 1'b1;
                        cw.out_lo = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                cw.tstate[T5_IDX] = 1'b1;
                case (cur_op)
                    OP_LDA: begin
                        cw.ram_ce = 1'b1;
                        cw.a_la   = 1'b1;
                    end
                    OP_ADD: begin
                        cw.ram_ce = 1'b1;
                        cw.b_lb   = 1'b1;
                    end
                    OP_SUB: begin
                        // Subtract select set up while B loads, held into T6.
                        cw.ram_ce = 1'b1;
                        cw.b_lb   = 1'b1;
                        cw.alu_su = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                cw.tstate[T6_IDX] = 1'b1;
                case (cur_op)
                    OP_ADD: begin
                        cw.alu_eu = 1'b1;
                        cw.a_la   = 1'b1;
                    end
                    OP_SUB: begin
                        cw.alu_eu = 1'b1;
                        cw.a_la   = 1'b1;
                        cw.alu_su = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                cw.hlt = 1'b1;
            end
            default: ;
        endcase
        if (retires_at(state, cur_op, EARLY_RETIRE)) begin
            cw.pc_ep = 1'b1;
        end
    end

endmodule

// File: rtl/sap_controller.sv
// Controller-sequencer: T-state ring, opcode latch and halt handling.
// Strobes come from sap_ctrl_decode; reset forces the all-quiet word with
// the PC held clear, asynchronously to the clock.
module sap_controller
    import sap_pkg::*;
#(
    parameter bit EARLY_RETIRE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    sap_controller_if.master    bus
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op_q;
    ctrl_word_t cw_dec;
    ctrl_word_t cw;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode copy taken during T4 so T5/T6 do not depend on the IR staying put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 4'd0;
        end else if (state_q == S_T4) begin
            op_q <= bus.opcode;
        end
    end

    // Next-state: fetch ring, then execute until the retire state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = S_T4;
            S_T4: begin
                if (bus.opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else if (retires_at(S_T4, bus.opcode, EARLY_RETIRE)) begin
                    state_d = S_T1;
                end else begin
                    state_d = S_T5;
                end
            end
            S_T5: begin
                if (retires_at(S_T5, op_q, EARLY_RETIRE)) begin
                    state_d = S_T1;
                end else begin
                    state_d = S_T6;
                end
            end
            S_T6:   state_d = S_T1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_INIT;
        endcase
    end

    sap_ctrl_decode #(
        .EARLY_RETIRE (EARLY_RETIRE)
    ) u_decode (
        .state  (state_q),
        .opcode (bus.opcode),
        .op_q   (op_q),
        .cw     (cw_dec)
    );

    // Reset overrides the decoded word immediately, not at the next edge.
    always_comb begin
        cw = cw_dec;
        if (rst) begin
            cw = '0;
        end
    end

    assign bus.pc_clr_n = cw.pc_clr_n;
    assign bus.pc_cp    = cw.pc_cp;
    assign bus.pc_ep    = cw.pc_ep;
    assign bus.pc_lp    = cw.pc_lp;
    assign bus.mar_lm   = cw.mar_lm;
    assign bus.ram_ce   = cw.ram_ce;
    assign bus.ir_li    = cw.ir_li;
    assign bus.ir_ei    = cw.ir_ei;
    assign bus.a_la     = cw.a_la;
    assign bus.a_ea     = cw.a_ea;
    assign bus.b_lb     = cw.b_lb;
    assign bus.alu_su   = cw.alu_su;
    assign bus.alu_eu   = cw.alu_eu;
    assign bus.out_lo   = cw.out_lo;
    assign bus.hlt      = cw.hlt;
    assign bus.tstate   = cw.tstate;

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: one instance per retire mode, a table of
// per-cycle expected control words, and hand-written halt/async-reset runs.
module tb_sap_controller;

    // Bench-side packing of the outputs: bit 20 pc_clr_n ... bits 5:0 tstate.
    localparam logic [20:0] CLR = 21'd1 << 20;
    localparam logic [20:0] CP  = 21'd1 << 19;
    localparam logic [20:0] EP  = 21'd1 << 18;
    localparam logic [20:0] LP  = 21'd1 << 17;
    localparam logic [20:0] MAR = 21'd1 << 16;
    localparam logic [20:0] RAM = 21'd1 << 15;
    localparam logic [20:0] LI  = 21'd1 << 14;
    localparam logic [20:0] EI  = 21'd1 << 13;
    localparam logic [20:0] LA  = 21'd1 << 12;
    localparam logic [20:0] EA  = 21'd1 << 11;
    localparam logic [20:0] LB  = 21'd1 << 10;
    localparam logic [20:0] SU  = 21'd1 << 9;
    localparam logic [20:0] EU  = 21'd1 << 8;
    localparam logic [20:0] LO  = 21'd1 << 7;
    localparam logic [20:0] HLT = 21'd1 << 6;
    localparam logic [20:0] TS1 = 21'd1 << 0;
    localparam logic [20:0] TS2 = 21'd1 << 1;
    localparam logic [20:0] TS3 = 21'd1 << 2;
    localparam logic [20:0] TS4 = 21'd1 << 3;
    localparam logic [20:0] TS5 = 21'd1 << 4;
    localparam logic [20:0] TS6 = 21'd1 << 5;

    typedef struct {
        bit          do_rst;
        bit          sel;
        logic [3:0]  op;
        logic [20:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    vec_t vecs[$];
    logic [20:0] exp_q[$];
    logic ep_q0;
    logic ep_q1;
    logic [20:0] act0;
    logic [20:0] act1;

    sap_controller_if bus0 ();
    sap_controller_if bus1 ();

    sap_controller #(.EARLY_RETIRE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sap_controller #(.EARLY_RETIRE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign act0 = {bus0.pc_clr_n, bus0.pc_cp, bus0.pc_ep, bus0.pc_lp, bus0.mar_lm,
                   bus0.ram_ce, bus0.ir_li, bus0.ir_ei, bus0.a_la, bus0.a_ea,
                   bus0.b_lb, bus0.alu_su, bus0.alu_eu, bus0.out_lo, bus0.hlt,
                   bus0.tstate};
    assign act1 = {bus1.pc_clr_n, bus1.pc_cp, bus1.pc_ep, bus1.pc_lp, bus1.mar_lm,
                   bus1.ram_ce, bus1.ir_li, bus1.ir_ei, bus1.a_la, bus1.a_ea,
                   bus1.b_lb, bus1.alu_su, bus1.alu_eu, bus1.out_lo, bus1.hlt,
                   bus1.tstate};

    // Clock and initial reset level.
    initial begin
        clk = 1'b0;
        rst = 1'b1;
        forever #5 clk = ~clk;
    end

    // PC bus drive takes effect one cycle after pc_ep.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ep_q0 <= 1'b0;
            ep_q1 <= 1'b0;
        end else begin
            ep_q0 <= bus0.pc_ep;
            ep_q1 <= bus1.pc_ep;
        end
    end

    // Structural invariants sampled mid-cycle.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (32'(ep_q0) + 32'(bus0.ram_ce) + 32'(bus0.ir_ei) + 32'(bus0.a_ea) + 32'(bus0.alu_eu) > 1) begin
                n_miss++;
                $display("FAIL inv_bus dut0 at %0t: more than one bus driver", $time);
            end
            if (32'(ep_q1) + 32'(bus1.ram_ce) + 32'(bus1.ir_ei) + 32'(bus1.a_ea) + 32'(bus1.alu_eu) > 1) begin
                n_miss++;
                $display("FAIL inv_bus dut1 at %0t: more than one bus driver", $time);
            end
            if ((bus0.pc_cp && bus0.pc_lp) || (bus1.pc_cp && bus1.pc_lp)) begin
                n_miss++;
                $display("FAIL inv_cp_lp at %0t: pc_cp and pc_lp both high", $time);
            end
            if (!$onehot0(bus0.tstate) || !$onehot0(bus1.tstate)) begin
                n_miss++;
                $display("FAIL inv_tstate at %0t: got %b / %b, need one-hot or zero",
                         $time, bus0.tstate, bus1.tstate);
            end
        end
    end

    task automatic add(input bit r, input bit s, input logic [3:0] op, input logic [20:0] e);
        vec_t v;
        v.do_rst = r;
        v.sel    = s;
        v.op     = op;
        v.exp    = e;
        vecs.push_back(v);
    endtask

    task automatic add_fetch(input bit s);
        add(1'b0, s, 4'd0, CLR | MAR | TS1);
        add(1'b0, s, 4'd0, CLR | CP  | TS2);
        add(1'b0, s, 4'd0, CLR | RAM | LI | TS3);
    endtask

    // Scoreboard compare: expected word comes off exp_q.
    task automatic check(input string name, input logic [20:0] act);
        logic [20:0] e;
        e = exp_q.pop_front();
        n_vec++;
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, e);
        end
    endtask

    // Hold rst for three cycles; returns on a negedge just after release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.push_back(21'd0);
        check("rst_held_dut0", act0);
        exp_q.push_back(21'd0);
        check("rst_held_dut1", act1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit s, input logic [3:0] op, input logic [20:0] e, input string name);
        @(negedge clk);
        if (s) bus1.opcode = op; else bus0.opcode = op;
        #1;
        exp_q.push_back(e);
        check(name, s ? act1 : act0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        bus0.opcode = 4'd0;
        bus1.opcode = 4'd0;

        // EARLY_RETIRE=0: ADD, NOP 0101, JMP each run the full six states.
        add(1'b1, 1'b0, 4'd0, EP);
        add_fetch(1'b0);
        add(1'b0, 1'b0, 4'd1, CLR | EI | MAR | TS4);
        add(1'b0, 1'b0, 4'd7, CLR | RAM | LB | TS5);
        add(1'b0, 1'b0, 4'd7, CLR | EU | LA | EP | TS6);
        add_fetch(1'b0);
        add(1'b0, 1'b0, 4'd5, CLR | TS4);
        add(1'b0, 1'b0, 4'd5, CLR | TS5);
        add(1'b0, 1'b0, 4'd5, CLR | EP | TS6);
        add_fetch(1'b0);
        add(1'b0, 1'b0, 4'd3, CLR | EI | LP | TS4);
        add(1'b0, 1'b0, 4'd0, CLR | TS5);
        add(1'b0, 1'b0, 4'd0, CLR | EP | TS6);
        add_fetch(1'b0);

        // EARLY_RETIRE=1: SUB, LDA, JMP, OUT, NOP, HLT.
        add(1'b1, 1'b1, 4'd0, EP);
        add_fetch(1'b1);
        add(1'b0, 1'b1, 4'd2, CLR | EI | MAR | TS4);
        add(1'b0, 1'b1, 4'd0, CLR | RAM | LB | SU | TS5);
        add(1'b0, 1'b1, 4'd0, CLR | EU | LA | SU | EP | TS6);
        add_fetch(1'b1);
        add(1'b0, 1'b1, 4'd0, CLR | EI | MAR | TS4);
        add(1'b0, 1'b1, 4'd9, CLR | RAM | LA | EP | TS5);
        add_fetch(1'b1);
        add(1'b0, 1'b1, 4'd3, CLR | EI | LP | EP | TS4);
        add_fetch(1'b1);
        add(1'b0, 1'b1, 4'he, CLR | EA | LO | EP | TS4);
        add_fetch(1'b1);
        add(1'b0, 1'b1, 4'd5, CLR | EP | TS4);
        add_fetch(1'b1);
        add(1'b0, 1'b1, 4'hf, CLR | TS4);
        add(1'b0, 1'b1, 4'hf, CLR | HLT);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset();
            else @(negedge clk);
            if (vecs[i].sel) bus1.opcode = vecs[i].op; else bus0.opcode = vecs[i].op;
            #1;
            exp_q.push_back(vecs[i].exp);
            check($sformatf("vec%0d_dut%0d", i, vecs[i].sel), vecs[i].sel ? act1 : act0);
        end

        // HALT is absorbing whatever the IR presents.
        for (int i = 0; i < 22; i++) begin
            step(1'b1, 4'(i), CLR | HLT, $sformatf("halt_hold%0d", i));
        end
        do_reset();
        #1;
        exp_q.push_back(EP);
        check("halt_exit_init", act1);

        // Asynchronous reset in the middle of an ADD's T5.
        step(1'b0, 4'd0, CLR | MAR | TS1, "pre_t1");
        step(1'b0, 4'd0, CLR | CP | TS2, "pre_t2");
        step(1'b0, 4'd0, CLR | RAM | LI | TS3, "pre_t3");
        step(1'b0, 4'd1, CLR | EI | MAR | TS4, "pre_t4");
        step(1'b0, 4'd1, CLR | RAM | LB | TS5, "pre_t5");
        #3;
        rst = 1'b1;
        #1;
        exp_q.push_back(21'd0);
        check("async_rst_dut0", act0);
        exp_q.push_back(21'd0);
        check("async_rst_dut1", act1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.push_back(EP);
        check("post_rst_init", act0);
        step(1'b0, 4'd0, CLR | MAR | TS1, "post_t1");
        step(1'b0, 4'd0, CLR | CP | TS2, "post_t2");
        step(1'b0, 4'd0, CLR | RAM | LI | TS3, "post_t3");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
